sequence_generator: RTL
=======================

Name: sequence_generator

Overview:
- Serial bit-pattern transmitter; the driving end of the serial line that sequence_detector consumes.
- Accepts PAT_W-bit patterns plus a repeat count through a valid/ready handshake and buffers them in a small FIFO.
- Shifts each pattern out MSB first, one bit per clk, with no gaps between patterns.
- Used as stimulus source and loopback partner for sequence_detector.

Parameters:
- PAT_W, 3, pattern width in bits.
- DEPTH, 4, FIFO entries; power of two.
- CNT_W, 4, width of the repeat-count field.
- IDLE_BIT, 0, value driven on x when no bit is valid.

Ports:
- clk  input  1  single clock, rising-edge.
- reset  input  1  synchronous, active-high reset.
- pat_in  input  PAT_W  pattern to transmit.
- rep_in  input  CNT_W  extra repetitions; entry is sent rep_in+1 times.
- pat_valid  input  1  pat_in/rep_in valid.
- pat_ready  output  1  FIFO can accept; equals !full (combinational from count).
- abort  input  1  synchronous flush of FIFO and current transmission.
- x  output  1  serial data, registered.
- x_valid  output  1  x carries a pattern bit, registered.
- last  output  1  final bit of final repetition of an entry, registered.
- busy  output  1  state != IDLE or FIFO non-empty.

Behaviour:
- **Reset** (reset=1 at an edge): FIFO emptied, state IDLE, x=IDLE_BIT, x_valid=0, last=0; pat_ready=1 and busy=0 after that edge. Reset overrides abort and pat_valid.
- **Push:** occurs at an edge where pat_valid & pat_ready & !abort & !reset. No push when full. Pop and push in the same cycle are allowed.
- **FSM states:** IDLE and SHIFT. Internal state: shift register sr[PAT_W-1:0], bit counter bcnt, repeat counter rcnt, saved pattern.
- **IDLE:**
  - FIFO empty: x=IDLE_BIT, x_valid=0.
  - FIFO non-empty at an edge: pop head, load sr/rcnt, x<=pat[PAT_W-1], x_valid<=1, bcnt<=PAT_W-1, go to SHIFT.
  - Latency: a push at edge E0 into an empty FIFO while IDLE gives the first bit valid after E1.
- **SHIFT, each edge:**
  - If bcnt != 0: x <= next lower bit, bcnt decrements.
  - If bcnt == 0 (last bit on x) and rcnt != 0: rcnt decrements, reload saved pattern, x <= MSB. No gap.
  - If bcnt == 0, rcnt == 0, FIFO non-empty: pop next entry, x <= its MSB. No gap, x_valid stays 1.
  - If bcnt == 0, rcnt == 0, FIFO empty: x_valid<=0, x<=IDLE_BIT, go to IDLE.
- **last:** 1 exactly when x shows bit 0 of the final repetition of an entry; otherwise 0.
- **Abort** at an edge (no reset): FIFO cleared, state IDLE, x_valid=0, x=IDLE_BIT, last=0 after the edge. A push offered on that same edge is dropped.
- **FIFO pointers:** wrap modulo DEPTH. Count is CLOG2(DEPTH)+1 bits; full when count==DEPTH.

Test Plan:
- **Reset:** hold reset 1 cycle -> x=0, x_valid=0, last=0, pat_ready=1, busy=0.
- **Single entry:** push 3'b101 rep 0 at E0 -> after E1,E2,E3: x=1,0,1, x_valid=1, last only after E3; after E4 x_valid=0, busy=0.
- **Repeats:** push 3'b110 rep 2 -> 9 contiguous bits 110110110; last only on the 9th bit; x_valid never drops.
- **Backpressure:** push 3'b111 rep 3, then offer 3'b000..3'b100 on consecutive cycles -> after 4 are stored pat_ready=0 and 3'b100 is held until the first pop. Output is 12 bits of 1 followed by 000 001 010 011 100 contiguously; last fires 6 times.
- **Abort:** abort mid-pattern with 2 entries queued and a push offered the same cycle -> next cycle x_valid=0, x=0, busy=0, pat_ready=1; the offered push is not transmitted.
- **Loopback:** push all 8 patterns 000..111 rep 0 into sequence_detector driven on the same clk -> each yNNN pulses at least once, and each pulse aligns with the detector's latency after the matching last.

Source files
------------

// File: rtl/sequence_generator.sv
// Serial pattern transmitter: queues {pattern, repeat} entries in a small FIFO
// and shifts each entry out MSB first, back to back, with no idle gaps.
module sequence_generator #(
    parameter int   PAT_W    = 3,
    parameter int   DEPTH    = 4,
    parameter int   CNT_W    = 4,
    parameter logic IDLE_BIT = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [PAT_W-1:0] pat_in,
    input  logic [CNT_W-1:0] rep_in,
    input  logic             pat_valid,
    output logic             pat_ready,
    input  logic             abort,
    output logic             x,
    output logic             x_valid,
    output logic             last,
    output logic             busy
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int BW = (PAT_W > 1) ? $clog2(PAT_W) : 1;

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state, state_n;
    logic [PAT_W-1:0] mem_pat [DEPTH];
    logic [CNT_W-1:0] mem_rep [DEPTH];
    logic [AW-1:0]    wptr, rptr;
    logic [CW-1:0]    count;
    logic [PAT_W-1:0] sr, sr_n, save, save_n;
    logic [BW-1:0]    bcnt, bcnt_n;
    logic [CNT_W-1:0] rcnt, rcnt_n;
    logic             x_n, x_valid_n, last_n;
    logic             push, pop, load;
    logic [PAT_W-1:0] head_pat;
    logic [CNT_W-1:0] head_rep;

    assign pat_ready = (count != CW'(DEPTH));
    assign push      = pat_valid & pat_ready & ~abort;
    assign busy      = (state != IDLE) || (count != '0);
    assign head_pat  = mem_pat[rptr];
    assign head_rep  = mem_rep[rptr];

    always_comb begin
        state_n   = state;
        sr_n      = sr;
        save_n    = save;
        bcnt_n    = bcnt;
        rcnt_n    = rcnt;
        x_n       = IDLE_BIT;
        x_valid_n = 1'b0;
        last_n    = 1'b0;
        pop       = 1'b0;
        load      = 1'b0;
        if (abort) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (count != '0) load = 1'b1;
                end
                SHIFT: begin
                    if (bcnt != '0) begin
                        x_n       = sr[PAT_W-1];
                        sr_n      = sr << 1;
                        bcnt_n    = bcnt - BW'(1);
                        x_valid_n = 1'b1;
                        last_n    = (bcnt == BW'(1)) && (rcnt == '0);
                    end else if (rcnt != '0) begin
                        // Replay the saved pattern without a gap bit.
                        rcnt_n    = rcnt - CNT_W'(1);
                        sr_n      = save << 1;
                        x_n       = save[PAT_W-1];
                        bcnt_n    = BW'(PAT_W-1);
                        x_valid_n = 1'b1;
                        last_n    = (PAT_W == 1) && (rcnt == CNT_W'(1));
                    end else if (count != '0) begin
                        load = 1'b1;
                    end else begin
                        state_n = IDLE;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
        if (load) begin
            pop       = 1'b1;
            state_n   = SHIFT;
            save_n    = head_pat;
            sr_n      = head_pat << 1;
            rcnt_n    = head_rep;
            bcnt_n    = BW'(PAT_W-1);
            x_n       = head_pat[PAT_W-1];
            x_valid_n = 1'b1;
            last_n    = (PAT_W == 1) && (head_rep == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            sr      <= '0;
            save    <= '0;
            bcnt    <= '0;
            rcnt    <= '0;
            x       <= IDLE_BIT;
            x_valid <= 1'b0;
            last    <= 1'b0;
        end else begin
            state   <= state_n;
            sr      <= sr_n;
            save    <= save_n;
            bcnt    <= bcnt_n;
            rcnt    <= rcnt_n;
            x       <= x_n;
            x_valid <= x_valid_n;
            last    <= last_n;
        end
    end

    // FIFO bookkeeping; abort discards everything queued.
    always_ff @(posedge clk) begin
        if (reset || abort) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= (wptr == AW'(DEPTH-1)) ? '0 : wptr + AW'(1);
            if (pop)  rptr <= (rptr == AW'(DEPTH-1)) ? '0 : rptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_pat[wptr] <= pat_in;
            mem_rep[wptr] <= rep_in;
        end
    end

endmodule
